// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: producer latency classes,
// opcode definitions and the counter-width helper.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MUL  = 2'd2,
    LAT_RSVD = 2'd3
  } lat_sel_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_MULT  = 6'h18,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } opcode_e;

  // Counter width that holds the larger latency; never narrower than 1 bit.
  function automatic int cnt_width(input int load_lat, input int mul_lat);
    int mx;
    mx = (load_lat > mul_lat) ? load_lat : mul_lat;
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard-control response bundle between the pipeline
// (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int RAW = 5
);

  logic           id_valid;
  logic [RAW-1:0] id_rs;
  logic [RAW-1:0] id_rt;
  logic           id_uses_rs;
  logic           id_uses_rt;
  logic [RAW-1:0] id_rd;
  logic           id_regwrite;
  logic [1:0]     id_lat_sel;
  logic           branch_taken;

  logic           stall;
  logic           pc_write;
  logic           ifid_write;
  logic           bubble_idex;
  logic           flush_ifid;
  logic           issue;
  logic           busy;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_rd, id_regwrite, id_lat_sel, branch_taken,
    input  stall, pc_write, ifid_write, bubble_idex, flush_ifid, issue, busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_rd, id_regwrite, id_lat_sel, branch_taken,
    output stall, pc_write, ifid_write, bubble_idex, flush_ifid, issue, busy
  );

endinterface

// File: rtl/hazard_scoreboard_sb_cnt.sv
// One per-register scoreboard counter: loads a latency on issue, otherwise
// counts down to zero and holds there.
module sb_cnt #(
  parameter int CW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          nonzero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A fresh load wins over the decrement of the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nonzero = |cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard that stalls the ID stage on RAW/WAW hazards against
// multi-cycle producers. Optional stall_cycles counter under HZ_STALL_PERF_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int RAW      = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  hazard_scoreboard_if.slave   sb
`ifdef HZ_STALL_PERF_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int CW = cnt_width(LOAD_LAT, MUL_LAT);

  logic [NREG-1:1] nz;
  logic [NREG-1:1] load_vec;
  logic [NREG-1:0] nz_all;
  logic            raw_hit;
  logic            waw_hit;
  logic            stall_int;
  logic            issue_int;
  logic            do_load;
  logic [CW-1:0]   load_val;

  // Register 0 is never tracked, so its busy bit is a constant zero.
  assign nz_all = {nz, 1'b0};

  always_comb begin
    raw_hit = sb.id_valid &&
              ((sb.id_uses_rs && nz_all[sb.id_rs]) ||
               (sb.id_uses_rt && nz_all[sb.id_rt]));
    waw_hit = sb.id_valid && sb.id_regwrite && nz_all[sb.id_rd];
    stall_int = (raw_hit || waw_hit) && !sb.branch_taken;
    issue_int = sb.id_valid && !stall_int && !sb.branch_taken;
    do_load   = issue_int && sb.id_regwrite && (sb.id_rd != '0);
  end

  always_comb begin
    load_val = '0;
    case (lat_sel_e'(sb.id_lat_sel))
      LAT_LOAD: load_val = CW'(LOAD_LAT);
      LAT_MUL:  load_val = CW'(MUL_LAT);
      default:  load_val = '0;
    endcase
  end

  always_comb begin
    load_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      load_vec[r] = do_load && (sb.id_rd == RAW'(r));
    end
  end

  generate
    for (genvar r = 1; r < NREG; r++) begin : g_cnt
      sb_cnt #(
        .CW(CW)
      ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (load_vec[r]),
        .load_val (load_val),
        .dec      (1'b1),
        .nonzero  (nz[r])
      );
    end
  endgenerate

  assign sb.stall       = stall_int;
  assign sb.pc_write    = ~stall_int;
  assign sb.ifid_write  = ~stall_int;
  assign sb.bubble_idex = stall_int | sb.branch_taken;
  assign sb.flush_ifid  = sb.branch_taken;
  assign sb.issue       = issue_int;
  assign sb.busy        = |nz;

`ifdef HZ_STALL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_int && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-style bench for hazard_scoreboard: directed hazard scenarios
// followed by random traffic, checked against a cycle-accurate "free at" model.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NREG     = 32;
  localparam int RAW      = 5;
  localparam int LOAD_LAT = 1;
  localparam int MUL_LAT  = 3;

  typedef struct packed {
    logic stall;
    logic issue;
    logic bubble;
    logic flush;
    logic busy;
    logic pc_write;
    logic ifid_write;
  } exp_t;

  logic clock;
  logic reset;
  hazard_scoreboard_if #(.RAW(RAW)) hif ();
`ifdef HZ_STALL_PERF_EN
  logic [31:0] stall_cycles;
`endif

  hazard_scoreboard #(
    .NREG(NREG), .RAW(RAW), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sb    (hif)
`ifdef HZ_STALL_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  // Model: first cycle at which each register is no longer pending.
  int   free_at[NREG];
  int   model_stalls = 0;

  function automatic bit reg_pending(input int r);
    return (r != 0) && (free_at[r] > cyc);
  endfunction

  // Drive one ID-stage cycle, queue its expected response, advance the model.
  task automatic applyStimulus(input bit v, input int rs, input int rt,
                               input bit urs, input bit urt, input int rd,
                               input bit rw, input int lat, input bit br,
                               input bit rst);
    exp_t e;
    bit   hit;
    int   l;
    @(posedge clock);
    #1;
    hif.id_valid     = v;
    hif.id_rs        = RAW'(rs);
    hif.id_rt        = RAW'(rt);
    hif.id_uses_rs   = urs;
    hif.id_uses_rt   = urt;
    hif.id_rd        = RAW'(rd);
    hif.id_regwrite  = rw;
    hif.id_lat_sel   = 2'(lat);
    hif.branch_taken = br;
    reset            = rst;

    hit = v && ((urs && reg_pending(rs)) || (urt && reg_pending(rt)) ||
                (rw && reg_pending(rd)));
    e.stall      = hit && !br;
    e.issue      = v && !e.stall && !br;
    e.bubble     = e.stall || br;
    e.flush      = br;
    e.busy       = 1'b0;
    for (int r = 1; r < NREG; r++) if (reg_pending(r)) e.busy = 1'b1;
    e.pc_write   = !e.stall;
    e.ifid_write = !e.stall;
    exp_q.push_back(e);

    if (rst) begin
      for (int r = 0; r < NREG; r++) free_at[r] = 0;
      model_stalls = 0;
    end else begin
      if (e.stall) model_stalls++;
      if (e.issue && rw && rd != 0) begin
        l = (lat == 1) ? LOAD_LAT : (lat == 2) ? MUL_LAT : 0;
        free_at[rd] = cyc + 1 + l;
      end
    end
    cyc++;
  endtask

  task automatic checkOutput();
    exp_t e;
    exp_t a;
    e = exp_q.pop_front();
    a = '{hif.stall, hif.issue, hif.bubble_idex, hif.flush_ifid, hif.busy,
          hif.pc_write, hif.ifid_write};
    total++;
    if (a === e) passed++;
    else $display("[TB] FAIL cycle%0d outputs{stall,issue,bubble,flush,busy,pcw,ifw}: got %b expected %b",
                  cyc - 1, a, e);
  endtask

  // Monitor: the DUT presents a combinational response every driven cycle.
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) checkOutput();
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int r = 0; r < NREG; r++) free_at[r] = 0;
    hif.id_valid = 0; hif.id_rs = '0; hif.id_rt = '0; hif.id_uses_rs = 0;
    hif.id_uses_rt = 0; hif.id_rd = '0; hif.id_regwrite = 0;
    hif.id_lat_sel = '0; hif.branch_taken = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);

    // Reset state check, then load r5 followed by add r6,r5,r5.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 5, 1, LAT_LOAD, 0, 0);
    applyStimulus(1, 5, 5, 1, 1, 6, 1, LAT_ALU, 0, 0);
    applyStimulus(1, 5, 5, 1, 1, 6, 1, LAT_ALU, 0, 0);

    // Mul r7, dependent held until it issues.
    applyStimulus(1, 0, 0, 0, 0, 7, 1, LAT_MUL, 0, 0);
    repeat (4) applyStimulus(1, 7, 1, 1, 1, 9, 1, LAT_ALU, 0, 0);
    // Mul r7, independent writer of r8.
    applyStimulus(1, 0, 0, 0, 0, 7, 1, LAT_MUL, 0, 0);
    applyStimulus(1, 1, 2, 1, 1, 8, 1, LAT_ALU, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load to r0 never creates a hazard.
    applyStimulus(1, 0, 0, 0, 0, 0, 1, LAT_LOAD, 0, 0);
    repeat (2) applyStimulus(1, 0, 0, 1, 1, 3, 1, LAT_ALU, 0, 0);

    // Branch overrides a pending stall; counter still expires on schedule.
    applyStimulus(1, 0, 0, 0, 0, 5, 1, LAT_LOAD, 0, 0);
    applyStimulus(1, 5, 0, 1, 0, 6, 1, LAT_ALU, 1, 0);
    applyStimulus(1, 5, 0, 1, 0, 6, 1, LAT_ALU, 0, 0);

    // Reset in the middle of a mul stall.
    applyStimulus(1, 0, 0, 0, 0, 7, 1, LAT_MUL, 0, 0);
    applyStimulus(1, 7, 0, 1, 0, 9, 1, LAT_ALU, 0, 0);
    applyStimulus(1, 7, 0, 1, 0, 9, 1, LAT_ALU, 0, 1);
    applyStimulus(1, 7, 0, 1, 0, 9, 1, LAT_ALU, 0, 0);

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
    end

    @(negedge clock);
    #1;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("[TB] FAIL queue_drain: %0d entries left, expected 0", exp_q.size());

`ifdef HZ_STALL_PERF_EN
    @(posedge clock);
    #1;
    total++;
    if (stall_cycles == 32'(model_stalls)) passed++;
    else $display("[TB] FAIL stall_cycles: got %0d expected %0d", stall_cycles, model_stalls);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers; register 0 is hard-wired zero and never tracked.
REQ-002 Parameter RAW, default 5: register address width, equal to $clog2(NREG).
REQ-003 Parameter LOAD_LAT, default 1: stall cycles that a load imposes on an immediately dependent instruction; legal range 0..15.
REQ-004 Parameter MUL_LAT, default 3: stall cycles that a multi-cycle (mul/div) op imposes on an immediately dependent instruction; legal range 0..15.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 id_valid  in  1  ID stage holds a real instruction.
REQ-008 id_rs, id_rt  in  RAW each  source register numbers of the ID instruction.
REQ-009 id_uses_rs, id_uses_rt  in  1 each  the ID instruction reads the corresponding source.
REQ-010 id_rd  in  RAW  destination register of the ID instruction.
REQ-011 id_regwrite  in  1  the ID instruction writes id_rd.
REQ-012 id_lat_sel  in  2  producer class: 0 = ALU (no stall), 1 = load, 2 = mul; 3 is reserved and treated as 0.
REQ-013 branch_taken  in  1  branch resolved taken this cycle; the instruction in IF/ID is squashed.
REQ-014 stall  out  1  hold PC and IF/ID, inject a bubble.
REQ-015 pc_write, ifid_write  out  1 each  both equal ~stall.
REQ-016 bubble_idex  out  1  zero the ID/EX control signals; equals stall | branch_taken.
REQ-017 flush_ifid  out  1  equals branch_taken.
REQ-018 issue  out  1  the ID instruction advances into EX this cycle.
REQ-019 busy  out  1  at least one scoreboard counter is nonzero.

Function
REQ-020 The block SHALL hold one counter per register 1..NREG-1, each CW = $clog2(max(LOAD_LAT,MUL_LAT)+1) bits wide, with minimum width 1.
REQ-021 raw_hit SHALL be asserted when id_valid, and either (id_uses_rs, id_rs != 0, cnt[id_rs] != 0) or (id_uses_rt, id_rt != 0, cnt[id_rt] != 0).
REQ-022 waw_hit SHALL be asserted when id_valid, id_regwrite, id_rd != 0 and cnt[id_rd] != 0.
REQ-023 stall SHALL be combinational: (raw_hit | waw_hit) & ~branch_taken.
REQ-024 issue SHALL be id_valid & ~stall & ~branch_taken.
REQ-025 Each cycle, every nonzero counter SHALL decrement by 1 and saturate at 0.
REQ-026 On issue with id_regwrite and id_rd != 0, cnt[id_rd] SHALL be loaded with LOAD_LAT, MUL_LAT or 0 according to id_lat_sel; this load overrides the decrement for that register in the same cycle.
REQ-027 Counters SHALL be evaluated before the update, so a load issued in cycle t stalls a dependent ID instruction for exactly LOAD_LAT cycles, starting at t+1.
REQ-028 branch_taken SHALL NOT clear counters, because producers already issued still complete.
REQ-029 branch_taken SHALL take priority over stall: with both present, stall=0, pc_write=1 and flush_ifid=1.
REQ-030 A source equal to id_rd of the same instruction SHALL be checked against the pre-issue counter value only.

Reset
REQ-031 While reset is high at a clock edge, all counters SHALL clear to 0, including in the middle of a stall.
REQ-032 In the cycle after reset: stall=0, busy=0, pc_write=1, ifid_write=1, and bubble_idex=branch_taken.
REQ-033 The stall counter, when present (REQ-034), SHALL reset to 0.

Configuration
REQ-034 With macro HZ_STALL_PERF_EN defined, the block SHALL add output stall_cycles (32-bit); it increments on every cycle with stall=1, saturates at 0xFFFFFFFF, and clears on reset.
REQ-035 Without HZ_STALL_PERF_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Structure
REQ-036 The lat_sel encodings (LAT_ALU=0, LAT_LOAD=1, LAT_MUL=2) SHALL reside in the shared constants header alongside the opcode definitions.
REQ-037 Each per-register counter SHALL be one sub-module, sb_cnt, instantiated NREG-1 times in a generate loop; it takes load, load_val and dec inputs and produces a nonzero output.

Verification
REQ-038 Load to r5 issued at t, then "add r6,r5,r5" in ID at t+1 with LOAD_LAT=1 -> stall=1 for exactly 1 cycle; issue=1 at t+2.
REQ-039 Mul to r7 with MUL_LAT=3, then a dependent instruction at t+1 -> stall=1 at t+1..t+3 and issue at t+4; an independent instruction (r8) at t+1 -> no stall.
REQ-040 Load to r0, then a dependent on r0 -> stall never asserted and busy stays 0.
REQ-041 Stall active and branch_taken=1 in the same cycle -> stall=0, flush_ifid=1, bubble_idex=1, issue=0; counter for r5 still reaches 0 on schedule.
REQ-042 reset pulsed at t+2 during a MUL_LAT=3 stall on r7 -> at t+3 stall=0, busy=0, and the dependent instruction issues.
REQ-043 With HZ_STALL_PERF_EN defined, run the REQ-039 sequence -> stall_cycles=3; counter preset near 0xFFFFFFFF -> holds at 0xFFFFFFFF.
